ahb_sram_slave: RTL
===================

Name: ahb_sram_slave

Overview:
AHB-Lite SRAM slave, one per slave port of the interconnect. Produces the hrdata_x, hreadyout_x and hresp_x triplet that the slave-response multiplexer selects and returns to the master. It decodes address-phase controls, inserts a programmable number of wait states and performs byte, halfword and word reads and writes on an internal word array. Illegal transfers get the two-cycle ERROR response.

Parameters:
MEM_DEPTH, 256, number of 32-bit words; byte-address space is 0 to 4*MEM_DEPTH-1.
WAIT_STATES, 1, wait cycles (hreadyout=0) inserted before each OKAY completion; legal range 0..15.

Ports:
hclk  input  1  clock; all state changes on the rising edge.
hresetn  input  1  reset, asynchronous assert, active-low.
hsel  input  1  slave select from the address decoder.
haddr  input  32  byte address, address phase.
htrans  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
hwrite  input  1  1 = write, address phase.
hsize  input  3  000 byte, 001 halfword, 010 word.
hwdata  input  32  write data, valid during the data phase.
hready  input  1  bus-wide ready; the multiplexed hreadyout.
hrdata  output  32  read data.
hreadyout  output  1  this slave's ready.
hresp  output  1  0 OKAY, 1 ERROR.

Behaviour:
- Reset (hresetn=0, asynchronous) forces the following. Any in-flight transfer is aborted and no write commits. The memory array is not reset.
  - state IDLE
  - hreadyout=1
  - hresp=0
  - hrdata=0
  - wait counter=0
- Transfer acceptance: at a rising edge with hsel=1, hready=1 and htrans[1]=1. At acceptance, latch haddr, hwrite and hsize.
- No transfer: IDLE/BUSY or hsel=0 with hready=1 gives a zero-wait OKAY; state stays IDLE.
- Error check at acceptance; any one of these makes the transfer illegal:
  - hsize > 010
  - hsize=001 with haddr[0]=1
  - hsize=010 with haddr[1:0]!=00
  - haddr[31:2] >= MEM_DEPTH
- States:
  - IDLE: hreadyout=1, hresp=0.
    - Legal accept goes to ACCESS, counter loaded with WAIT_STATES.
    - Illegal accept goes to ERR1.
  - ACCESS: hreadyout = (counter==0); hresp=0.
    - Counter decrements each cycle while non-zero.
    - Completion cycle is the one with counter==0.
    - A write commits at the edge ending the completion cycle, using hwdata sampled at that edge.
    - A read drives hrdata in the completion cycle.
    - In the completion cycle hready=1, so a new accept can occur. The next state is then ACCESS, ERR1 or IDLE per the new transfer, with no bubble.
  - ERR1: hreadyout=0, hresp=1; always goes to ERR2.
  - ERR2: hreadyout=1, hresp=1. A new accept in this cycle is honoured as from IDLE; otherwise go to IDLE.
- Latency: an OKAY transfer's data phase lasts WAIT_STATES+1 cycles. With WAIT_STATES=0 it completes in the first data-phase cycle. ERROR always takes exactly 2 cycles and never writes memory.
- Byte lanes (little-endian):
  - byte: lane haddr[1:0]
  - halfword: lanes {haddr[1],0} and {haddr[1],1}
  - word: all 4 lanes
  - Unselected lanes of the stored word are unchanged.
- Read data:
  - The full 32-bit word at the latched address is returned, and the master extracts lanes.
  - hrdata=0 in all cycles other than a read completion cycle.
- Read-after-write: a read immediately following a write to the same word returns the newly written data.
- hwrite/haddr changes during wait cycles are ignored; the latched values are used.

Test Plan:
1. Reset mid-wait: WAIT_STATES=3, start a write then deassert hresetn during a wait cycle.
   - Outputs return immediately to hreadyout=1, hresp=0, hrdata=0.
   - A later read of that word shows the old value.
2. Word write/read: WAIT_STATES=1, write 0xDEADBEEF to 0x10, then read 0x10.
   - Each data phase has 1 cycle hreadyout=0, then hreadyout=1.
   - The read returns 0xDEADBEEF with hresp=0.
3. Byte/halfword lanes, with word 0x20 preloaded to 0x11223344:
   - write byte 0xAA at 0x21, then halfword 0x5566 at 0x22;
   - a word read of 0x20 returns 0x5566AA44.
4. Back-to-back pipelined transfers: WAIT_STATES=0, write 0x0000CAFE at 0x40 immediately followed by a read of 0x40.
   - No wait cycles occur.
   - The read returns 0x0000CAFE.
5. Error responses, each giving ERR1 (hreadyout=0, hresp=1) then ERR2 (hreadyout=1, hresp=1), with memory unchanged:
   - word at 0x02
   - halfword at 0x05
   - hsize=011
   - address 4*MEM_DEPTH = 0x400
6. IDLE/BUSY and unselected behaviour:
   - htrans=00 or 01, or hsel=0, keeps hreadyout=1, hresp=0, hrdata=0.
   - A NONSEQ issued during ERR2 is accepted and completes normally.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: programmable wait states, byte/half/word access,
// two-cycle ERROR response for misaligned, oversized or out-of-range transfers.
module ahb_sram_slave #(
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic        hresp
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [AW-1:0] idx_q;
    logic [1:0]  off_q;
    logic [2:0]  size_q;
    logic        wr_q;

    logic [31:0] mem [MEM_DEPTH];

    logic        accept;
    logic        bad_size;
    logic        bad_align;
    logic        bad_range;
    logic        illegal;
    logic        done;
    logic [3:0]  be;

    assign bad_size  = hsize[2] | (hsize[1:0] == 2'b11);
    assign bad_align = ((hsize == 3'b001) & haddr[0]) |
                       ((hsize == 3'b010) & (|haddr[1:0]));
    assign bad_range = {2'b00, haddr[31:2]} >= 32'(MEM_DEPTH);
    assign illegal   = bad_size | bad_align | bad_range;

    assign done      = (state_q == S_ACCESS) && (cnt_q == 4'd0);
    assign hreadyout = (state_q != S_ERR1) &&
                       !((state_q == S_ACCESS) && (cnt_q != 4'd0));
    assign hresp     = (state_q == S_ERR1) || (state_q == S_ERR2);
    assign hrdata    = (done && !wr_q) ? mem[idx_q] : 32'd0;

    // Only cycles where this slave is ready can start a new data phase.
    assign accept = hsel & hready & htrans[1] & hreadyout;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE:   state_d = S_IDLE;
            S_ACCESS: begin
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                else               state_d = S_IDLE;
            end
            S_ERR1:   state_d = S_ERR2;
            S_ERR2:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (accept) begin
            state_d = illegal ? S_ERR1 : S_ACCESS;
            cnt_d   = WAIT_STATES[3:0];
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            off_q   <= 2'd0;
            size_q  <= 3'd0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q  <= haddr[AW+1:2];
                off_q  <= haddr[1:0];
                size_q <= hsize;
                wr_q   <= hwrite;
            end
        end
    end

    always_comb begin
        be = 4'b1111;
        if (size_q == 3'b000)      be = 4'b0001 << off_q;
        else if (size_q == 3'b001) be = off_q[1] ? 4'b1100 : 4'b0011;
    end

    // Array is deliberately not reset; reset forces IDLE so done is low.
    always_ff @(posedge hclk) begin
        if (done && wr_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx_q][8*i +: 8] <= hwdata[8*i +: 8];
            end
        end
    end

endmodule
